// File: rtl/ctrl_pkg.sv
// Shared op/state encodings and default widths for the PC sequencer and its return stack.
package ctrl_pkg;

    localparam int PC_WIDTH_DEF    = 5;
    localparam int VALUE_WIDTH_DEF = 8;
    localparam int STACK_DEPTH_DEF = 16;

    typedef enum logic [2:0] {
        OP_NEXT    = 3'd0,
        OP_RET     = 3'd1,
        OP_JUMP    = 3'd2,
        OP_JZ      = 3'd3,
        OP_JNZ     = 3'd4,
        OP_RESTART = 3'd5,
        OP_CALL    = 3'd6,
        OP_HALT    = 3'd7
    } ctrl_op_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } ctrl_state_e;

    // Both HALTED and FAULT park the core.
    function automatic logic is_parked(input ctrl_state_e st);
        return (st != ST_RUN);
    endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO holding subroutine return addresses; level and full/empty flags are registered.
module return_stack
    import ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = PC_WIDTH_DEF,
    parameter int DEPTH      = STACK_DEPTH_DEF,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic [DATA_WIDTH-1:0] top_data,
    output logic [AW:0]           level,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]           level_r;
    logic [AW:0]           level_next_s;
    logic                  full_r;
    logic                  empty_r;
    logic [AW-1:0]         wr_idx_s;
    logic [AW-1:0]         rd_idx_s;
    logic                  do_push_s;

    // Slot addressing: the top entry sits one below the live level.
    always_comb begin
        wr_idx_s  = level_r[AW-1:0];
        rd_idx_s  = level_r[AW-1:0] - AW'(1);
        do_push_s = push && !full_r && !clear;
    end

    // Next level: clear wins, then a guarded push or pop.
    always_comb begin
        level_next_s = level_r;
        if (clear) begin
            level_next_s = (AW+1)'(0);
        end else if (push && !full_r) begin
            level_next_s = level_r + (AW+1)'(1);
        end else if (pop && !empty_r) begin
            level_next_s = level_r - (AW+1)'(1);
        end else begin
            level_next_s = level_r;
        end
    end

    // Level and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r <= (AW+1)'(0);
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            level_r <= level_next_s;
            full_r  <= (level_next_s == (AW+1)'(DEPTH));
            empty_r <= (level_next_s == (AW+1)'(0));
        end
    end

    // Storage array; contents are don't-care after reset so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_idx_s] <= push_data;
        end
    end

    assign top_data = mem_r[rd_idx_s];
    assign level    = level_r;
    assign full     = full_r;
    assign empty    = empty_r;

endmodule

// File: rtl/call_stack_controller.sv
// Program-counter sequencer: applies one decoded control op per cycle and owns the return stack.
module call_stack_controller
    import ctrl_pkg::*;
#(
    parameter int PC_WIDTH    = PC_WIDTH_DEF,
    parameter int VALUE_WIDTH = VALUE_WIDTH_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic                         clock,
    input  logic                         resetN,
    input  logic                         stall,
    input  logic                         opValid,
    input  logic [2:0]                   opCode,
    input  logic [PC_WIDTH-1:0]          target,
    input  logic [VALUE_WIDTH-1:0]       condValue,
    output logic [PC_WIDTH-1:0]          pc,
    output logic [$clog2(STACK_DEPTH):0] depth,
    output logic                         stackFull,
    output logic                         stackEmpty,
    output logic                         overflow,
    output logic                         underflow,
    output logic                         halted
);

    ctrl_state_e         state_r;
    ctrl_state_e         state_next_s;
    logic [PC_WIDTH-1:0] pc_r;
    logic [PC_WIDTH-1:0] pc_next_s;
    logic [PC_WIDTH-1:0] pc_inc_s;
    logic [PC_WIDTH-1:0] top_s;
    logic                overflow_r;
    logic                overflow_next_s;
    logic                underflow_r;
    logic                underflow_next_s;
    logic                halted_r;
    logic                push_s;
    logic                pop_s;
    logic                clear_s;
    logic                full_s;
    logic                empty_s;
    logic                cond_zero_s;
    ctrl_op_e            op_in_s;
    ctrl_op_e            op_eff_s;

    return_stack #(
        .DATA_WIDTH (PC_WIDTH),
        .DEPTH      (STACK_DEPTH)
    ) u_return_stack (
        .clk       (clock),
        .rst_n     (resetN),
        .clear     (clear_s),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (pc_inc_s),
        .top_data  (top_s),
        .level     (depth),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Decode helpers; an idle decoder slot behaves like NEXT while running.
    always_comb begin
        op_in_s     = ctrl_op_e'(opCode);
        op_eff_s    = opValid ? op_in_s : OP_NEXT;
        pc_inc_s    = pc_r + PC_WIDTH'(1);
        cond_zero_s = (condValue == VALUE_WIDTH'(0));
    end

    // Sequencer next-state, next-pc and stack control.
    always_comb begin
        state_next_s     = state_r;
        pc_next_s        = pc_r;
        overflow_next_s  = overflow_r;
        underflow_next_s = underflow_r;
        push_s           = 1'b0;
        pop_s            = 1'b0;
        clear_s          = 1'b0;
        if (stall) begin
            state_next_s = state_r;
        end else if (opValid && (op_in_s == OP_RESTART)) begin
            state_next_s     = ST_RUN;
            pc_next_s        = PC_WIDTH'(0);
            overflow_next_s  = 1'b0;
            underflow_next_s = 1'b0;
            clear_s          = 1'b1;
        end else begin
            case (state_r)
                ST_RUN: begin
                    case (op_eff_s)
                        OP_NEXT: pc_next_s = pc_inc_s;
                        OP_JUMP: pc_next_s = target;
                        OP_JZ:   pc_next_s = cond_zero_s ? target : pc_inc_s;
                        OP_JNZ:  pc_next_s = cond_zero_s ? pc_inc_s : target;
                        OP_CALL: begin
                            if (full_s) begin
                                overflow_next_s = 1'b1;
                                state_next_s    = ST_FAULT;
                            end else begin
                                push_s    = 1'b1;
                                pc_next_s = target;
                            end
                        end
                        OP_RET: begin
                            if (empty_s) begin
                                underflow_next_s = 1'b1;
                                state_next_s     = ST_FAULT;
                            end else begin
                                pop_s     = 1'b1;
                                pc_next_s = top_s;
                            end
                        end
                        OP_HALT: state_next_s = ST_HALTED;
                        default: pc_next_s = pc_inc_s;
                    endcase
                end
                ST_HALTED, ST_FAULT: state_next_s = state_r;
                default:             state_next_s = ST_FAULT;
            endcase
        end
    end

    // Sequencer state and output registers.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_r     <= ST_RUN;
            pc_r        <= PC_WIDTH'(0);
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            halted_r    <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            pc_r        <= pc_next_s;
            overflow_r  <= overflow_next_s;
            underflow_r <= underflow_next_s;
            halted_r    <= is_parked(state_next_s);
        end
    end

    assign pc         = pc_r;
    assign stackFull  = full_s;
    assign stackEmpty = empty_s;
    assign overflow   = overflow_r;
    assign underflow  = underflow_r;
    assign halted     = halted_r;

endmodule

// File: tb/tb_call_stack_controller.sv
// Directed bench for call_stack_controller with hand-computed expectations.
module tb_call_stack_controller;

    logic       clock;
    logic       resetN;
    logic       stall;
    logic       opValid;
    logic [2:0] opCode;
    logic [4:0] target;
    logic [7:0] condValue;
    logic [4:0] pc;
    logic [4:0] depth;
    logic       stackFull;
    logic       stackEmpty;
    logic       overflow;
    logic       underflow;
    logic       halted;

    int n_checks;
    int n_fails;

    localparam logic [2:0] NEXT    = 3'd0;
    localparam logic [2:0] RET     = 3'd1;
    localparam logic [2:0] JUMP    = 3'd2;
    localparam logic [2:0] JZ      = 3'd3;
    localparam logic [2:0] JNZ     = 3'd4;
    localparam logic [2:0] RESTART = 3'd5;
    localparam logic [2:0] CALL    = 3'd6;
    localparam logic [2:0] HALT    = 3'd7;

    call_stack_controller dut (
        .clock      (clock),
        .resetN     (resetN),
        .stall      (stall),
        .opValid    (opValid),
        .opCode     (opCode),
        .target     (target),
        .condValue  (condValue),
        .pc         (pc),
        .depth      (depth),
        .stackFull  (stackFull),
        .stackEmpty (stackEmpty),
        .overflow   (overflow),
        .underflow  (underflow),
        .halted     (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one op, let one rising edge consume it, return 1 time unit later.
    task automatic apply(input logic v, input logic [2:0] op, input logic [4:0] tgt,
                         input logic [7:0] cv);
        opValid   = v;
        opCode    = op;
        target    = tgt;
        condValue = cv;
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        resetN    = 1'b0;
        stall     = 1'b0;
        opValid   = 1'b0;
        opCode    = NEXT;
        target    = 5'd0;
        condValue = 8'd0;
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_pc", 32'(pc), 32'd0);
        check_eq("rst_depth", 32'(depth), 32'd0);
        check_eq("rst_empty", 32'(stackEmpty), 32'd1);
        check_eq("rst_full", 32'(stackFull), 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);
        resetN = 1'b1;

        for (int i = 1; i <= 3; i++) begin
            apply(1'b0, NEXT, 5'd0, 8'd0);
            check_eq("idle_pc", 32'(pc), 32'(i));
        end
        check_eq("idle_depth", 32'(depth), 32'd0);
        check_eq("idle_empty", 32'(stackEmpty), 32'd1);
        apply(1'b1, NEXT, 5'd0, 8'd0);
        check_eq("next_pc4", 32'(pc), 32'd4);

        apply(1'b1, CALL, 5'd20, 8'd0);
        check_eq("call_pc", 32'(pc), 32'd20);
        check_eq("call_depth", 32'(depth), 32'd1);
        apply(1'b1, JUMP, 5'd9, 8'd0);
        check_eq("jump_pc", 32'(pc), 32'd9);
        check_eq("jump_depth", 32'(depth), 32'd1);
        apply(1'b1, RET, 5'd0, 8'd0);
        check_eq("ret_pc", 32'(pc), 32'd5);
        check_eq("ret_depth", 32'(depth), 32'd0);
        check_eq("ret_empty", 32'(stackEmpty), 32'd1);

        for (int i = 1; i <= 16; i++) begin
            apply(1'b1, CALL, 5'd10, 8'd0);
            if (i == 15) check_eq("fill15_full", 32'(stackFull), 32'd0);
        end
        check_eq("fill_depth", 32'(depth), 32'd16);
        check_eq("fill_full", 32'(stackFull), 32'd1);
        check_eq("fill_pc", 32'(pc), 32'd10);
        apply(1'b1, CALL, 5'd3, 8'd0);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
        check_eq("ovf_halted", 32'(halted), 32'd1);
        check_eq("ovf_pc", 32'(pc), 32'd10);
        check_eq("ovf_depth", 32'(depth), 32'd16);
        apply(1'b1, RESTART, 5'd0, 8'd0);
        check_eq("rs_pc", 32'(pc), 32'd0);
        check_eq("rs_depth", 32'(depth), 32'd0);
        check_eq("rs_ovf", 32'(overflow), 32'd0);
        check_eq("rs_halted", 32'(halted), 32'd0);
        check_eq("rs_full", 32'(stackFull), 32'd0);

        apply(1'b1, CALL, 5'd20, 8'd0);
        apply(1'b1, CALL, 5'd25, 8'd0);
        check_eq("nest_pc", 32'(pc), 32'd25);
        apply(1'b1, RET, 5'd0, 8'd0);
        check_eq("nest_ret1", 32'(pc), 32'd21);
        apply(1'b1, RET, 5'd0, 8'd0);
        check_eq("nest_ret2", 32'(pc), 32'd1);

        apply(1'b1, RET, 5'd0, 8'd0);
        check_eq("unf_flag", 32'(underflow), 32'd1);
        check_eq("unf_halted", 32'(halted), 32'd1);
        check_eq("unf_pc", 32'(pc), 32'd1);
        apply(1'b1, JUMP, 5'd7, 8'd0);
        check_eq("fault_jump_pc", 32'(pc), 32'd1);
        apply(1'b0, NEXT, 5'd0, 8'd0);
        check_eq("fault_idle_pc", 32'(pc), 32'd1);
        apply(1'b1, RESTART, 5'd0, 8'd0);
        check_eq("unf_clear", 32'(underflow), 32'd0);

        apply(1'b1, JZ, 5'd12, 8'h00);
        check_eq("jz_taken", 32'(pc), 32'd12);
        apply(1'b1, JNZ, 5'd3, 8'h00);
        check_eq("jnz_not", 32'(pc), 32'd13);
        apply(1'b1, JNZ, 5'd3, 8'hFF);
        check_eq("jnz_taken", 32'(pc), 32'd3);
        apply(1'b1, JZ, 5'd12, 8'h05);
        check_eq("jz_not", 32'(pc), 32'd4);

        apply(1'b1, HALT, 5'd0, 8'd0);
        check_eq("halt_flag", 32'(halted), 32'd1);
        check_eq("halt_pc", 32'(pc), 32'd4);
        apply(1'b1, NEXT, 5'd0, 8'd0);
        check_eq("halt_hold", 32'(pc), 32'd4);
        apply(1'b1, RESTART, 5'd0, 8'd0);

        apply(1'b1, JUMP, 5'd31, 8'd0);
        apply(1'b1, NEXT, 5'd0, 8'd0);
        check_eq("wrap_pc", 32'(pc), 32'd0);

        stall = 1'b1;
        apply(1'b1, CALL, 5'd20, 8'd0);
        check_eq("stall_pc", 32'(pc), 32'd0);
        check_eq("stall_depth", 32'(depth), 32'd0);
        stall = 1'b0;

        apply(1'b1, CALL, 5'd6, 8'd0);
        check_eq("pre_rst_depth", 32'(depth), 32'd1);
        opValid = 1'b1;
        opCode  = CALL;
        target  = 5'd17;
        #2;
        resetN = 1'b0;
        #1;
        check_eq("arst_pc", 32'(pc), 32'd0);
        check_eq("arst_depth", 32'(depth), 32'd0);
        @(posedge clock);
        #1;
        check_eq("arst_hold_pc", 32'(pc), 32'd0);
        check_eq("arst_hold_empty", 32'(stackEmpty), 32'd1);
        resetN = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
